nebula_arb_client: RTL
======================

Name: nebula_arb_client

Overview:
- Requester-side endpoint for the nebula round-robin arbiter; one instance per arbiter input.
- Buffers flits from an upstream source in a small FIFO and drives one arbiter req line while the FIFO is non-empty.
- Consumes the matching grant bit and forwards one flit per granted cycle to the shared output stage.
- Tracks head/tail packet framing and, optionally, flags starvation when the arbiter withholds grant too long.

Parameters:
- FLIT_WIDTH, 64, width of flit payload
- DEPTH, 4, FIFO entries (power of two, >=2)
- CNT_WIDTH, $clog2(DEPTH+1), width of occupancy count
- STARVE_LIMIT, 16, cycles of req without grant before starve asserts (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream flit valid
- in_ready  out  1  FIFO can accept a flit this cycle
- in_flit  in  FLIT_WIDTH  upstream flit payload
- in_head  in  1  flit is packet head
- in_tail  in  1  flit is packet tail (head&tail = single-flit packet)
- req  out  1  request to arbiter
- grant  in  1  this client's bit of the arbiter one-hot grant
- out_valid  out  1  flit transferred this cycle
- out_flit  out  FLIT_WIDTH  FIFO head payload
- out_head  out  1  head flag of FIFO head entry
- out_tail  out  1  tail flag of FIFO head entry
- count  out  CNT_WIDTH  FIFO occupancy
- proto_err  out  1  sticky framing error
- starve  out  1  starvation flag

Behaviour:
- Reset (rst_n=0 at posedge): count=0, rd/wr pointers=0, FSM=IDLE, proto_err=0, starve counter=0.
  - Hence in_ready=1, req=0, out_valid=0, starve=0.
  - Reset mid-packet discards buffered flits without error.
- in_ready = (count != DEPTH). Derived from registered count only; does not consider a same-cycle pop.
- push = in_valid & in_ready. Writes {in_head, in_tail, in_flit} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- req = (count != 0). Combinational from registered state only, never from grant (avoids a loop with the combinational arbiter).
- pop = req & grant. out_valid = pop, in the same cycle (zero-latency transfer).
  - out_flit/out_head/out_tail always show the head entry; they are don't-care when count=0.
  - rd_ptr wraps DEPTH-1 -> 0.
- grant while req=0: ignored. No pop, no error.
- Simultaneous push and pop: count unchanged.
  - When full, push is refused regardless of pop.
  - When empty, pop cannot occur (req=0); a pushed flit is first requestable next cycle (1-cycle in->req latency).
- Framing FSM, evaluated on popped flits:
  - IDLE, pop head&tail: stay IDLE.
  - IDLE, pop head&!tail: go to IN_PKT.
  - IDLE, pop !head: proto_err<=1, stay IDLE.
  - IN_PKT, pop !head&tail: go to IDLE.
  - IN_PKT, pop !head&!tail: stay IN_PKT.
  - IN_PKT, pop head: proto_err<=1; next state follows that flit's tail bit (tail -> IDLE, else IN_PKT).
  - proto_err is sticky until reset.
- Flits of different clients may interleave at the arbiter (per-flit arbitration). The client does not hold req across empty-FIFO gaps inside a packet.

Optional Feature:
- Macro NEBULA_ARB_CLIENT_STARVE_EN.
- Defined:
  - wait counter (width $clog2(STARVE_LIMIT+1)) increments each cycle req & !grant, saturating at STARVE_LIMIT.
  - Counter clears on pop or when req=0.
  - starve = (counter == STARVE_LIMIT), registered; deasserts the cycle after the clearing event.
- Undefined: no counter logic; starve tied 0.

Test Plan:
- Reset, then in_valid=0 for 3 cycles -> req=0, out_valid=0, in_ready=1, count=0, proto_err=0.
- Push single flit 0xA5 (head=tail=1) with grant held 1 -> req=1 the next cycle, out_valid=1 with out_flit=0xA5 that cycle, count back to 0 the following cycle, no proto_err.
- grant=0, push 6 flits with DEPTH=4 -> first 4 accepted, in_ready=0 while count=4. Then grant=1 for 4 cycles -> out_flit order matches push order across pointer wrap; req drops after the 4th pop.
- Full FIFO, in_valid=1 and grant=1 together -> push refused that cycle, count 4->3. Push accepted next cycle, count 3.
- Pop sequence head(!tail), body, head -> proto_err=1 after the second head and stays 1 through further valid packets until rst_n=0.
- STARVE_EN, one flit queued, grant=0 -> starve=1 after 16 cycles of req. grant=1 for one cycle -> flit popped, starve=0 next cycle. Without the macro -> starve=0 throughout.

Source files
------------

// File: rtl/nebula_arb_client.sv
// Requester-side arbiter endpoint: flit FIFO, req/grant handshake and packet framing check.
// Optional starvation flag enabled by defining NEBULA_ARB_CLIENT_STARVE_EN.
module nebula_arb_client #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1),
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_head,
    input  logic                  in_tail,
    output logic                  req,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_head,
    output logic                  out_tail,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  proto_err,
    output logic                  starve
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [FLIT_WIDTH-1:0] flit;
    } entry_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    entry_t           mem [DEPTH];
    entry_t           head_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count_q;
    state_t           state;
    logic             proto_err_q;
    logic             push;
    logic             pop;

    // req and in_ready look only at registered occupancy, never at grant or a same-cycle pop.
    assign in_ready = (count_q != CNT_WIDTH'(DEPTH));
    assign req      = (count_q != '0);
    assign push     = in_valid & in_ready;
    assign pop      = req & grant;

    assign head_entry = mem[rd_ptr];
    assign out_valid  = pop;
    assign out_flit   = head_entry.flit;
    assign out_head   = head_entry.head;
    assign out_tail   = head_entry.tail;
    assign count      = count_q;
    assign proto_err  = proto_err_q;

    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{head: in_head, tail: in_tail, flit: in_flit};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Framing check on popped flits; after any head the next state follows that flit's tail bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            proto_err_q <= 1'b0;
        end else if (pop) begin
            case (state)
                IDLE: begin
                    if (!head_entry.head) begin
                        proto_err_q <= 1'b1;
                    end else if (!head_entry.tail) begin
                        state <= IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (head_entry.head) begin
                        proto_err_q <= 1'b1;
                    end
                    state <= head_entry.tail ? IDLE : IN_PKT;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NEBULA_ARB_CLIENT_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!req || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign starve = (wait_cnt == WAIT_W'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

endmodule
